// File: rtl/tcb_mng_copy.sv
// tcb_mng_copy: TCB manager that copies cfg_len words from cfg_src to cfg_dst
// ports: cfg_* start request with source/destination/length, sts_* busy/done/error/word count,
//        tcb_* manager request (vld/wen/adr/siz/byt/wdt) and delayed response (rdy/rdt/err)
module tcb_mng_copy #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int DLY = 1,
  parameter int LW  = 16
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [AW-1:0]   cfg_src,
  input  logic [AW-1:0]   cfg_dst,
  input  logic [LW-1:0]   cfg_len,
  output logic            sts_busy,
  output logic            sts_done,
  output logic            sts_err,
  output logic [LW-1:0]   sts_cnt,
  output logic            tcb_vld,
  input  logic            tcb_rdy,
  output logic            tcb_wen,
  output logic [AW-1:0]   tcb_adr,
  output logic [1:0]      tcb_siz,
  output logic [DW/8-1:0] tcb_byt,
  output logic [DW-1:0]   tcb_wdt,
  input  logic [DW-1:0]   tcb_rdt,
  input  logic            tcb_err
);
  localparam int BW = DW / 8;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP} state_t;
  state_t        r_state, w_nxt;
  logic [AW-1:0] r_src, r_dst, r_adr;
  logic [LW-1:0] r_len, r_cnt;
  logic [DW-1:0] r_wdt;
  logic [2:0]    r_dly;
  logic          r_wen, r_done, r_err;
  logic          w_rsp, w_rd, w_last, w_idle_start;
  // the response is sampled in the transfer cycle itself without delay,
  // otherwise in the DLY-th cycle spent in the response state
  always_comb begin
    w_rsp = (DLY == 0) ? ((r_state == RD_REQ || r_state == WR_REQ) && tcb_rdy)
                       : ((r_state == RD_RSP || r_state == WR_RSP) && r_dly == 3'(DLY - 1));
    w_rd = r_state == RD_REQ || r_state == RD_RSP;
    w_last = r_cnt + LW'(1) == r_len;
    w_idle_start = r_state == IDLE && cfg_start;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    w_nxt = (cfg_start && cfg_len != '0) ? RD_REQ : IDLE;
      RD_REQ:  w_nxt = !tcb_rdy ? RD_REQ : (DLY > 0) ? RD_RSP : tcb_err ? IDLE : WR_REQ;
      RD_RSP:  w_nxt = !w_rsp ? RD_RSP : tcb_err ? IDLE : WR_REQ;
      WR_REQ:  w_nxt = !tcb_rdy ? WR_REQ : (DLY > 0) ? WR_RSP : (tcb_err || w_last) ? IDLE : RD_REQ;
      WR_RSP:  w_nxt = !w_rsp ? WR_RSP : (tcb_err || w_last) ? IDLE : RD_REQ;
      default: w_nxt = IDLE;
    endcase
  end
  always_comb begin
    tcb_vld  = r_state == RD_REQ || r_state == WR_REQ;
    sts_busy = r_state != IDLE;
  end
  // r_src/r_dst advance after each completed word so the next request
  // address is ready in a register before the request state is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_adr  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_wdt  <= '0;
      r_dly  <= '0;
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_state != IDLE && w_nxt == IDLE) || (w_idle_start && cfg_len == '0);
      r_dly  <= (r_state == RD_RSP || r_state == WR_RSP) ? r_dly + 3'd1 : 3'd0;
      if (w_idle_start) begin
        r_src <= cfg_src;
        r_dst <= cfg_dst;
        r_adr <= cfg_src;
        r_len <= cfg_len;
        r_cnt <= '0;
        r_err <= 1'b0;
        r_wen <= 1'b0;
      end
      if (w_rsp && tcb_err) r_err <= 1'b1;
      if (w_rsp && !tcb_err && w_rd) begin
        r_wdt <= tcb_rdt;
        r_adr <= r_dst;
        r_wen <= 1'b1;
      end
      if (w_rsp && !tcb_err && !w_rd) begin
        r_cnt <= r_cnt + LW'(1);
        r_src <= r_src + AW'(BW);
        r_dst <= r_dst + AW'(BW);
        r_adr <= r_src + AW'(BW);
        r_wen <= 1'b0;
      end
    end
  end
  assign tcb_wen  = r_wen;
  assign tcb_adr  = r_adr;
  assign tcb_wdt  = r_wdt;
  assign tcb_siz  = 2'($clog2(BW));
  assign tcb_byt  = '1;
  assign sts_done = r_done;
  assign sts_err  = r_err;
  assign sts_cnt  = r_cnt;
endmodule
